// File: rtl/instr_pkg.sv
// Shared decode definitions: instruction field positions, opcode constants and default widths.
package instr_pkg;

   localparam int DEF_DW   = 8;
   localparam int DEF_NREG = 8;
   localparam int DEF_AW   = $clog2(DEF_NREG);
   localparam int DEF_OPW  = 5;
   localparam int DEF_IW   = 24;

   localparam int OP_MSB      = 23;
   localparam int OP_LSB      = 19;
   localparam int RD_MSB      = 18;
   localparam int RD_LSB      = 16;
   localparam int RS_MSB      = 15;
   localparam int RS_LSB      = 13;
   localparam int IMM_SEL_BIT = 12;
   localparam int RSV_MSB     = 11;
   localparam int RSV_LSB     = 8;
   localparam int IMM_MSB     = 7;
   localparam int IMM_LSB     = 0;

   localparam logic [DEF_OPW-1:0] OP_NOP   = 5'b00000;
   localparam logic [DEF_OPW-1:0] OP_STORE = 5'b10001;

   // Only NOP and store leave the destination register untouched.
   function automatic logic writes_rd(input logic [DEF_OPW-1:0] op);
      return (op != OP_NOP) && (op != OP_STORE);
   endfunction

endpackage

// File: rtl/dec_regfile.sv
// NREG x DW register file: two combinational read ports, one synchronous write port,
// and write-through forwarding so a read in the writeback cycle sees the new value.
module dec_regfile
   import instr_pkg::*;
#(
   parameter  int DW   = DEF_DW,
   parameter  int NREG = DEF_NREG,
   localparam int AW   = $clog2(NREG)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we,
   input  logic [AW-1:0] wa,
   input  logic [DW-1:0] wd,
   input  logic [AW-1:0] ra_a,
   input  logic [AW-1:0] ra_b,
   output logic [DW-1:0] rdata_a,
   output logic [DW-1:0] rdata_b
);

   logic [DW-1:0] mem [NREG];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) mem[i] <= '0;
      end else if (we) begin
         mem[wa] <= wd;
      end
   end

   // A write landing this cycle is the newest value of that register.
   assign rdata_a = (we && (wa == ra_a)) ? wd : mem[ra_a];
   assign rdata_b = (we && (wa == ra_b)) ? wd : mem[ra_b];

endmodule

// File: rtl/instr_decode_block.sv
// Decode/issue stage: register file, per-register pending scoreboard, RAW stall logic
// and the registered operand interface towards the execution block.
module instr_decode_block
   import instr_pkg::*;
#(
   parameter  int DW   = DEF_DW,
   parameter  int NREG = DEF_NREG,
   parameter  int OPW  = DEF_OPW,
   parameter  int IW   = DEF_IW,
   localparam int AW   = $clog2(NREG)
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [IW-1:0]  if_instr,
   input  logic           if_valid,
   output logic           if_ready,
   input  logic           wb_en,
   input  logic [AW-1:0]  wb_addr,
   input  logic [DW-1:0]  wb_data,
   output logic [OPW-1:0] op_dec,
   output logic [DW-1:0]  A,
   output logic [DW-1:0]  B,
   output logic [DW-1:0]  data_in,
   output logic           dec_valid,
   output logic [AW-1:0]  dec_rd,
   output logic           dec_wb
);

   // Fetch handshake: a transfer happens at a rising edge where if_valid && if_ready;
   // fetch holds if_instr stable while if_valid && !if_ready; if_ready is high whenever
   // if_valid is low and drops only for an unresolved read-after-write hazard.

   logic [OPW-1:0]  op;
   logic [AW-1:0]   rd;
   logic [AW-1:0]   rs;
   logic            imm_sel;
   logic [DW-1:0]   imm;
   logic [3:0]      unused_rsvd;
   logic [DW-1:0]   rdata_a;
   logic [DW-1:0]   rdata_b;
   logic [NREG-1:0] sb;
   logic [NREG-1:0] sb_next;
   logic            rd_busy;
   logic            rs_busy;
   logic            stall;
   logic            issue;

   assign op          = if_instr[OP_MSB:OP_LSB];
   assign rd          = if_instr[RD_MSB:RD_LSB];
   assign rs          = if_instr[RS_MSB:RS_LSB];
   assign imm_sel     = if_instr[IMM_SEL_BIT];
   assign imm         = if_instr[IMM_MSB:IMM_LSB];
   assign unused_rsvd = if_instr[RSV_MSB:RSV_LSB];

   dec_regfile #(
      .DW   (DW),
      .NREG (NREG)
   ) u_rf (
      .clk     (clk),
      .reset   (reset),
      .we      (wb_en),
      .wa      (wb_addr),
      .wd      (wb_data),
      .ra_a    (rd),
      .ra_b    (rs),
      .rdata_a (rdata_a),
      .rdata_b (rdata_b)
   );

   // A writeback arriving this cycle resolves the hazard; the bypass supplies the value.
   assign rd_busy  = sb[rd] && !(wb_en && (wb_addr == rd));
   assign rs_busy  = !imm_sel && sb[rs] && !(wb_en && (wb_addr == rs));
   assign stall    = if_valid && (rd_busy || rs_busy);
   assign if_ready = !stall;
   assign issue    = if_valid && !stall;

   // Set is applied after clear: an issue to X in a writeback-to-X cycle leaves X pending.
   always_comb begin
      sb_next = sb;
      if (wb_en) sb_next[wb_addr] = 1'b0;
      if (issue && writes_rd(op)) sb_next[rd] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sb <= '0;
      end else begin
         sb <= sb_next;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         op_dec    <= OP_NOP;
         A         <= '0;
         B         <= '0;
         data_in   <= '0;
         dec_valid <= 1'b0;
         dec_rd    <= '0;
         dec_wb    <= 1'b0;
      end else if (issue) begin
         op_dec    <= op;
         A         <= rdata_a;
         B         <= imm_sel ? imm : rdata_b;
         data_in   <= imm;
         dec_valid <= 1'b1;
         dec_rd    <= rd;
         dec_wb    <= writes_rd(op);
      end else begin
         // Bubble: operand fields keep their last values.
         op_dec    <= OP_NOP;
         dec_valid <= 1'b0;
         dec_wb    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_instr_decode_block.sv
// Bench for instr_decode_block: directed scenarios plus a randomized run, all checked
// against an architectural model of registers, pending flags and issued instructions.
module tb_instr_decode_block;

   localparam int W = 34;

   logic        clk = 1'b0;
   logic        reset;
   logic [23:0] if_instr;
   logic        if_valid;
   logic        if_ready;
   logic        wb_en;
   logic [2:0]  wb_addr;
   logic [7:0]  wb_data;
   logic [4:0]  op_dec;
   logic [7:0]  A;
   logic [7:0]  B;
   logic [7:0]  data_in;
   logic        dec_valid;
   logic [2:0]  dec_rd;
   logic        dec_wb;

   always #5 clk = ~clk;

   instr_decode_block dut (
      .clk       (clk),
      .reset     (reset),
      .if_instr  (if_instr),
      .if_valid  (if_valid),
      .if_ready  (if_ready),
      .wb_en     (wb_en),
      .wb_addr   (wb_addr),
      .wb_data   (wb_data),
      .op_dec    (op_dec),
      .A         (A),
      .B         (B),
      .data_in   (data_in),
      .dec_valid (dec_valid),
      .dec_rd    (dec_rd),
      .dec_wb    (dec_wb)
   );

   logic [W-1:0] dut_out;
   assign dut_out = {op_dec, A, B, data_in, dec_valid, dec_rd, dec_wb};

   logic [W-1:0] exp_q[$];
   logic [W-1:0] exp_out;
   int           n_checks = 0;
   int           n_fail   = 0;

   // Architectural model state
   logic [7:0] m_regs [8];
   logic [7:0] m_pend = 8'h00;
   logic [4:0] m_op   = 5'h00;
   logic [7:0] m_a    = 8'h00;
   logic [7:0] m_b    = 8'h00;
   logic [7:0] m_d    = 8'h00;
   logic       m_v    = 1'b0;
   logic [2:0] m_rd   = 3'd0;
   logic       m_wb   = 1'b0;
   logic       exp_ready = 1'b1;
   logic       obs_ready;

   function automatic logic [23:0] mk(input logic [4:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs, input logic isel,
                                      input logic [7:0] imm);
      logic [3:0] rsv;
      rsv = 4'($urandom_range(0, 15));
      return {op, rd, rs, isel, rsv, imm};
   endfunction

   // One clock: sample if_ready mid-cycle, predict the edge from the model, then step past it.
   task automatic cycle();
      logic [4:0] op;
      logic [2:0] rd;
      logic [2:0] rs;
      logic       isel;
      logic [7:0] imm;
      logic [7:0] va;
      logic [7:0] vb;
      logic       hz;
      logic       acc;
      @(negedge clk);
      obs_ready = if_ready;
      op   = if_instr[23:19];
      rd   = if_instr[18:16];
      rs   = if_instr[15:13];
      isel = if_instr[12];
      imm  = if_instr[7:0];
      va = (wb_en && wb_addr == rd) ? wb_data : m_regs[rd];
      vb = isel ? imm : ((wb_en && wb_addr == rs) ? wb_data : m_regs[rs]);
      hz = (m_pend[rd] && !(wb_en && wb_addr == rd)) ||
           (!isel && m_pend[rs] && !(wb_en && wb_addr == rs));
      exp_ready = !(if_valid && hz);
      acc = if_valid && exp_ready;
      if (reset) begin
         for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
         m_pend = 8'h00;
         {m_op, m_a, m_b, m_d, m_v, m_rd, m_wb} = '0;
      end else begin
         if (acc) begin
            m_op = op; m_a = va; m_b = vb; m_d = imm; m_v = 1'b1; m_rd = rd;
            m_wb = (op != 5'h00) && (op != 5'h11);
         end else begin
            m_op = 5'h00; m_v = 1'b0; m_wb = 1'b0;
         end
         if (wb_en) begin
            m_regs[wb_addr] = wb_data;
            m_pend[wb_addr] = 1'b0;
         end
         if (acc && m_wb) m_pend[rd] = 1'b1;
      end
      exp_q.push_back({m_op, m_a, m_b, m_d, m_v, m_rd, m_wb});
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [W-1:0] zero_out;
      zero_out = '0;
      reset = 1'b1; if_valid = 1'b0; if_instr = 24'h0; wb_en = 1'b0; wb_addr = 3'd0; wb_data = 8'h00;
      for (int i = 0; i < 2; i++) begin
         cycle();
         exp_out = exp_q.pop_front();
         n_checks++;
         if (dut_out !== exp_out) begin n_fail++; $display("FAIL reset outputs: got %h want %h", dut_out, exp_out); end
      end
      n_checks++;
      if (dut_out !== zero_out) begin n_fail++; $display("FAIL reset zero: got %h want %h", dut_out, zero_out); end
      n_checks++;
      if (if_ready !== 1'b1) begin n_fail++; $display("FAIL reset if_ready: got %b want 1", if_ready); end
      n_checks++;
      if (dut.sb !== 8'h00) begin n_fail++; $display("FAIL reset sb: got %h want 00", dut.sb); end
      reset = 1'b0;
   endtask

   task automatic test_issue_imm();
      logic [W-1:0] want;
      want = {5'h01, 8'h00, 8'h40, 8'h40, 1'b1, 3'd2, 1'b1};
      if_instr = mk(5'h01, 3'd2, 3'd0, 1'b1, 8'h40); if_valid = 1'b1;
      cycle();
      exp_out = exp_q.pop_front();
      n_checks++;
      if (dut_out !== exp_out) begin n_fail++; $display("FAIL issue_imm model: got %h want %h", dut_out, exp_out); end
      n_checks++;
      if (dut_out !== want) begin n_fail++; $display("FAIL issue_imm outputs: got %h want %h", dut_out, want); end
      n_checks++;
      if (dut.sb !== m_pend || dut.sb[2] !== 1'b1) begin n_fail++; $display("FAIL issue_imm sb: got %h want %h", dut.sb, m_pend); end
      if_valid = 1'b0;
   endtask

   task automatic test_raw_stall();
      if_instr = mk(5'h02, 3'd3, 3'd2, 1'b0, 8'($urandom)); if_valid = 1'b1; wb_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         exp_out = exp_q.pop_front();
         n_checks++;
         if (dut_out !== exp_out) begin n_fail++; $display("FAIL raw_stall outputs: got %h want %h", dut_out, exp_out); end
         n_checks++;
         if (obs_ready !== 1'b0 || dec_valid !== 1'b0) begin
            n_fail++; $display("FAIL raw_stall bubble: got ready=%b valid=%b want 0 0", obs_ready, dec_valid);
         end
      end
      wb_en = 1'b1; wb_addr = 3'd2; wb_data = 8'hC0;
      cycle();
      exp_out = exp_q.pop_front();
      n_checks++;
      if (dut_out !== exp_out) begin n_fail++; $display("FAIL raw_release outputs: got %h want %h", dut_out, exp_out); end
      n_checks++;
      if (obs_ready !== 1'b1 || dec_valid !== 1'b1 || B !== 8'hC0) begin
         n_fail++; $display("FAIL raw_release bypass: got ready=%b valid=%b B=%h want 1 1 c0", obs_ready, dec_valid, B);
      end
      n_checks++;
      if (dut.sb !== m_pend || dut.sb[2] !== 1'b0) begin n_fail++; $display("FAIL raw_release sb: got %h want %h", dut.sb, m_pend); end
      if_valid = 1'b0; wb_en = 1'b0;
   endtask

   task automatic test_same_reg();
      if_instr = mk(5'h03, 3'd4, 3'($urandom_range(0, 7)), 1'b1, 8'h05); if_valid = 1'b1;
      cycle();
      exp_out = exp_q.pop_front();
      n_checks++;
      if (dut_out !== exp_out) begin n_fail++; $display("FAIL same_reg first: got %h want %h", dut_out, exp_out); end
      if_instr = mk(5'h03, 3'd4, 3'($urandom_range(0, 7)), 1'b1, 8'h06);
      wb_en = 1'b1; wb_addr = 3'd4; wb_data = 8'h11;
      cycle();
      exp_out = exp_q.pop_front();
      n_checks++;
      if (dut_out !== exp_out) begin n_fail++; $display("FAIL same_reg second: got %h want %h", dut_out, exp_out); end
      n_checks++;
      if (obs_ready !== 1'b1 || A !== 8'h11) begin
         n_fail++; $display("FAIL same_reg bypass: got ready=%b A=%h want 1 11", obs_ready, A);
      end
      n_checks++;
      if (dut.sb[4] !== 1'b1 || dut.u_rf.mem[4] !== 8'h11) begin
         n_fail++; $display("FAIL same_reg set_wins: got sb4=%b r4=%h want 1 11", dut.sb[4], dut.u_rf.mem[4]);
      end
      if_valid = 1'b0; wb_en = 1'b0;
   endtask

   task automatic test_nop_store();
      logic [2:0] drain [2];
      drain[0] = 3'd3; drain[1] = 3'd4;
      for (int i = 0; i < 2; i++) begin
         wb_en = 1'b1; wb_addr = drain[i]; wb_data = 8'($urandom);
         cycle();
         exp_out = exp_q.pop_front();
         n_checks++;
         if (dut_out !== exp_out) begin n_fail++; $display("FAIL drain outputs: got %h want %h", dut_out, exp_out); end
      end
      wb_en = 1'b0;
      n_checks++;
      if (dut.sb !== 8'h00) begin n_fail++; $display("FAIL drain sb: got %h want 00", dut.sb); end
      if_instr = mk(5'h00, 3'd6, 3'($urandom_range(0, 7)), 1'b1, 8'($urandom)); if_valid = 1'b1;
      cycle();
      exp_out = exp_q.pop_front();
      n_checks++;
      if (dut_out !== exp_out) begin n_fail++; $display("FAIL nop outputs: got %h want %h", dut_out, exp_out); end
      n_checks++;
      if (dec_valid !== 1'b1 || dec_wb !== 1'b0 || dut.sb !== 8'h00) begin
         n_fail++; $display("FAIL nop flags: got valid=%b wb=%b sb=%h want 1 0 00", dec_valid, dec_wb, dut.sb);
      end
      if_instr = mk(5'h11, 3'd5, 3'd1, 1'b0, 8'($urandom));
      cycle();
      exp_out = exp_q.pop_front();
      n_checks++;
      if (dut_out !== exp_out) begin n_fail++; $display("FAIL store outputs: got %h want %h", dut_out, exp_out); end
      n_checks++;
      if (dec_valid !== 1'b1 || dec_wb !== 1'b0 || dut.sb[5] !== 1'b0) begin
         n_fail++; $display("FAIL store flags: got valid=%b wb=%b sb5=%b want 1 0 0", dec_valid, dec_wb, dut.sb[5]);
      end
      if_instr = mk(5'h02, 3'd1, 3'd5, 1'b0, 8'($urandom));
      cycle();
      exp_out = exp_q.pop_front();
      n_checks++;
      if (obs_ready !== 1'b1 || dut_out !== exp_out) begin
         n_fail++; $display("FAIL after_store: got ready=%b out=%h want 1 %h", obs_ready, dut_out, exp_out);
      end
      if_valid = 1'b0; wb_en = 1'b1; wb_addr = 3'd1; wb_data = 8'($urandom);
      cycle();
      exp_out = exp_q.pop_front();
      n_checks++;
      if (dut_out !== exp_out || dut.sb !== m_pend) begin
         n_fail++; $display("FAIL store_drain: got %h sb=%h want %h sb=%h", dut_out, dut.sb, exp_out, m_pend);
      end
      wb_en = 1'b0;
   endtask

   task automatic test_reset_mid_stall();
      logic [W-1:0] zero_out;
      zero_out = '0;
      if_instr = mk(5'h01, 3'd7, 3'd0, 1'b1, 8'($urandom)); if_valid = 1'b1;
      cycle();
      exp_out = exp_q.pop_front();
      n_checks++;
      if (dut_out !== exp_out) begin n_fail++; $display("FAIL mid_stall setup: got %h want %h", dut_out, exp_out); end
      if_instr = mk(5'h02, 3'd0, 3'd7, 1'b0, 8'($urandom));
      for (int i = 0; i < 3; i++) begin
         cycle();
         exp_out = exp_q.pop_front();
         n_checks++;
         if (obs_ready !== 1'b0 || dut_out !== exp_out) begin
            n_fail++; $display("FAIL mid_stall hold: got ready=%b out=%h want 0 %h", obs_ready, dut_out, exp_out);
         end
      end
      reset = 1'b1; wb_en = 1'b1; wb_addr = 3'd3; wb_data = 8'h77;
      cycle();
      exp_out = exp_q.pop_front();
      reset = 1'b0; wb_en = 1'b0;
      n_checks++;
      if (dut_out !== exp_out || dut_out !== zero_out) begin
         n_fail++; $display("FAIL mid_stall reset outputs: got %h want %h", dut_out, zero_out);
      end
      n_checks++;
      if (dut.sb !== 8'h00 || dut.u_rf.mem[3] !== 8'h00) begin
         n_fail++; $display("FAIL mid_stall reset state: got sb=%h r3=%h want 00 00", dut.sb, dut.u_rf.mem[3]);
      end
      n_checks++;
      if (if_ready !== 1'b1) begin n_fail++; $display("FAIL mid_stall reset ready: got %b want 1", if_ready); end
      if_valid = 1'b0;
   endtask

   task automatic test_back_to_back();
      if_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if_instr = mk(5'($urandom_range(1, 16)), 3'(i), 3'($urandom_range(0, 7)), 1'b1, 8'($urandom));
         cycle();
         exp_out = exp_q.pop_front();
         n_checks++;
         if (obs_ready !== 1'b1 || dec_valid !== 1'b1 || dut_out !== exp_out) begin
            n_fail++; $display("FAIL back_to_back %0d: got ready=%b out=%h want 1 %h", i, obs_ready, dut_out, exp_out);
         end
      end
      if_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wb_en = 1'b1; wb_addr = 3'(i); wb_data = 8'($urandom);
         cycle();
         exp_out = exp_q.pop_front();
         n_checks++;
         if (dut_out !== exp_out || dut.sb !== m_pend) begin
            n_fail++; $display("FAIL b2b_drain: got %h sb=%h want %h sb=%h", dut_out, dut.sb, exp_out, m_pend);
         end
      end
      wb_en = 1'b0;
   endtask

   task automatic test_random();
      int a;
      for (int c = 0; c < 400; c++) begin
         if (!(if_valid && !exp_ready)) begin
            if_valid = ($urandom_range(0, 3) != 0);
            if_instr = mk(5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)),
                          3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 8'($urandom));
         end
         wb_en = 1'b0;
         if (m_pend != 8'h00 && $urandom_range(0, 2) != 0) begin
            do a = $urandom_range(0, 7); while (!m_pend[a]);
            wb_en = 1'b1; wb_addr = 3'(a);
         end else if ($urandom_range(0, 7) == 0) begin
            wb_en = 1'b1; wb_addr = 3'($urandom_range(0, 7));
         end
         wb_data = 8'($urandom);
         cycle();
         exp_out = exp_q.pop_front();
         n_checks++;
         if (obs_ready !== exp_ready) begin n_fail++; $display("FAIL random ready c=%0d: got %b want %b", c, obs_ready, exp_ready); end
         n_checks++;
         if (dut_out !== exp_out) begin n_fail++; $display("FAIL random outputs c=%0d: got %h want %h", c, dut_out, exp_out); end
         n_checks++;
         if (dut.sb !== m_pend) begin n_fail++; $display("FAIL random sb c=%0d: got %h want %h", c, dut.sb, m_pend); end
      end
      if_valid = 1'b0; wb_en = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
      test_reset();
      test_issue_imm();
      test_raw_stall();
      test_same_reg();
      test_nop_store();
      test_reset_mid_stall();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      n_fail++;
      $display("FAIL watchdog: got timeout want completion");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
